// File: rtl/ft245_pkg.sv
// rtl/ft245_pkg.sv - shared constants for the FT245 device-side model
package ft245_pkg;

  // Every FT245 strobe and flag is active-low.
  localparam logic STROBE_ON = 1'b0;

  // Bit positions inside err_flags.
  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_COLLIDE   = 2;
  localparam int ERR_BUSWR     = 3;
  localparam int ERR_W         = 4;

  localparam int TXE_MARGIN_DEFAULT = 1;

endpackage

// File: rtl/ft245_device_sync_byte_fifo.sv
// rtl/ft245_device_sync_byte_fifo.sv - single-clock byte FIFO with occupancy count
module sync_byte_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wdata,
  input  logic          winc,
  input  logic          rinc,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  // A pop on an empty FIFO is ignored; a push into a full FIFO is allowed
  // only when the same cycle pops, since that frees the slot.
  assign do_pop  = rinc & ~empty;
  assign do_push = winc & (~full | do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array; contents are meaningless after reset because pointers restart.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/ft245_device.sv
// rtl/ft245_device.sv - FTDI-side responder for the synchronous FT245 FIFO bus
module ft245_device
  import ft245_pkg::*;
#(
  parameter int DOWN_AW    = 4,
  parameter int UP_AW      = 4,
  parameter int TXE_MARGIN = TXE_MARGIN_DEFAULT
) (
  input  logic             ft_clkout,
  input  logic             rst,
  input  logic [7:0]       ft_bus_in,
  output logic [7:0]       ft_bus_out,
  output logic             ft_bus_oe,
  output logic             ft_rxf_n,
  output logic             ft_txe_n,
  input  logic             ft_rd_n,
  input  logic             ft_wr_n,
  input  logic             ft_oe_n,
  input  logic             ft_siwu_n,
  input  logic [7:0]       host_wdata,
  input  logic             host_wvalid,
  output logic             host_wready,
  output logic [7:0]       host_rdata,
  output logic             host_rvalid,
  input  logic             host_rready,
  output logic [ERR_W-1:0] err_flags,
  output logic             siwu_seen
);

  localparam logic [UP_AW:0] UP_DEPTH = {1'b1, {UP_AW{1'b0}}};
  localparam logic [UP_AW:0] TXE_LIM  = (UP_AW+1)'(TXE_MARGIN);

  logic [7:0]       down_rdata;
  logic [DOWN_AW:0] down_count;
  logic             down_full, down_empty;
  logic [UP_AW:0]   up_count;
  logic             up_full, up_empty;

  logic rd_act, wr_act, oe_act, collide;
  logic rd_req, wr_req;
  logic down_push, down_pop, up_push, up_pop;

  logic [DOWN_AW:0] down_cnt_d;
  logic [UP_AW:0]   up_cnt_d;
  logic [UP_AW:0]   up_free_d;

  logic [7:0]       bus_out_q, bus_out_d;
  logic             bus_oe_q;
  logic             rxf_n_q, txe_n_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic             siwu_q;

  // Strobe decode. A write colliding with a read is always dropped, and a
  // write while the device may be driving the bus never lands either.
  assign rd_act  = (ft_rd_n == STROBE_ON);
  assign wr_act  = (ft_wr_n == STROBE_ON);
  assign oe_act  = (ft_oe_n == STROBE_ON);
  assign collide = rd_act & wr_act;
  assign rd_req  = oe_act & rd_act;
  assign wr_req  = wr_act & ~oe_act & ~collide;

  assign down_push = host_wvalid & host_wready;
  assign down_pop  = rd_req & ~down_empty;
  assign up_pop    = host_rvalid & host_rready;
  assign up_push   = wr_req & (~up_full | up_pop);

  assign host_wready = ~down_full;
  assign host_rvalid = ~up_empty;

  sync_byte_fifo #(.AW(DOWN_AW)) u_down (
    .clk   (ft_clkout),
    .rst   (rst),
    .wdata (host_wdata),
    .winc  (down_push),
    .rinc  (down_pop),
    .rdata (down_rdata),
    .count (down_count),
    .full  (down_full),
    .empty (down_empty)
  );

  sync_byte_fifo #(.AW(UP_AW)) u_up (
    .clk   (ft_clkout),
    .rst   (rst),
    .wdata (ft_bus_in),
    .winc  (up_push),
    .rinc  (up_pop),
    .rdata (host_rdata),
    .count (up_count),
    .full  (up_full),
    .empty (up_empty)
  );

  // Post-edge occupancy, error accumulation and captured read byte.
  always_comb begin
    down_cnt_d = down_count + {{DOWN_AW{1'b0}}, down_push} - {{DOWN_AW{1'b0}}, down_pop};
    up_cnt_d   = up_count + {{UP_AW{1'b0}}, up_push} - {{UP_AW{1'b0}}, up_pop};
    up_free_d  = UP_DEPTH - up_cnt_d;
    bus_out_d  = down_pop ? down_rdata : bus_out_q;
    err_d      = err_q;
    if (rd_req && down_empty)               err_d[ERR_UNDERFLOW] = 1'b1;
    if (wr_req && up_full && !up_pop)       err_d[ERR_OVERFLOW]  = 1'b1;
    if (collide)                            err_d[ERR_COLLIDE]   = 1'b1;
    if (wr_act && oe_act)                   err_d[ERR_BUSWR]     = 1'b1;
  end

  // Registered bus-side outputs and sticky status.
  always_ff @(posedge ft_clkout) begin
    if (rst) begin
      bus_out_q <= 8'h00;
      bus_oe_q  <= 1'b0;
      rxf_n_q   <= 1'b1;
      txe_n_q   <= 1'b1;
      err_q     <= '0;
      siwu_q    <= 1'b0;
    end else begin
      bus_out_q <= bus_out_d;
      bus_oe_q  <= oe_act;
      rxf_n_q   <= (down_cnt_d == '0);
      txe_n_q   <= (up_free_d < TXE_LIM);
      err_q     <= err_d;
      siwu_q    <= siwu_q | (ft_siwu_n == STROBE_ON);
    end
  end

  assign ft_bus_out = bus_out_q;
  assign ft_bus_oe  = bus_oe_q;
  assign ft_rxf_n   = rxf_n_q;
  assign ft_txe_n   = txe_n_q;
  assign err_flags  = err_q;
  assign siwu_seen  = siwu_q;

endmodule
